// File: rtl/hdc_pkg.sv
// Shared definitions for the hypervector classifier datapath.
//   DIMENSIONS_DEFAULT : default hypervector width D
//   bundler_state_t    : temporal bundler FSM states (ACCUM / OUTPUT)
//   cnt_width()        : width of a count that must hold 0..window
package hdc_pkg;

  localparam int DIMENSIONS_DEFAULT = 10000;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } bundler_state_t;

  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/temporal_bundler_if.sv
// Handshake bundle between the temporal bundler and its neighbours.
//   in_valid/in_ready/hv_in : input hypervector stream (accept = valid & ready)
//   flush                   : single-cycle request to close the window early
//   out_valid/out_ready     : output handshake (handoff = valid & ready)
//   hv_out/out_count        : majority hypervector and number of vectors bundled
// master = the surrounding system, slave = the bundler.
interface temporal_bundler_if
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = DIMENSIONS_DEFAULT,
  parameter int WINDOW     = 8
);
  localparam int CNT_W = cnt_width(WINDOW);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIMENSIONS-1:0] hv_in;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIMENSIONS-1:0] hv_out;
  logic [CNT_W-1:0]      out_count;

  modport master (
    output in_valid, hv_in, flush, out_ready,
    input  in_ready, out_valid, hv_out, out_count
  );

  modport slave (
    input  in_valid, hv_in, flush, out_ready,
    output in_ready, out_valid, hv_out, out_count
  );
endinterface

// File: rtl/temporal_bundler_bit_counter.sv
// bundle_bit_counter: per-dimension 1-bit counter for the temporal bundler.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear the count (takes priority over inc)
//   inc      : an input vector is accepted this cycle
//   bit_in   : this dimension's bit of the accepted vector
//   n        : effective vector count of the window, current input included
//   maj      : 2*c' > n, where c' includes the current bit
//   tie      : 2*c' == n
module bundle_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             bit_in,
  input  logic [CNT_W-1:0] n,
  output logic             maj,
  output logic             tie
);
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W:0]   twice;
  logic [CNT_W:0]   n_ext;

  assign count_nxt = count + CNT_W'(inc & bit_in);
  // One extra bit so 2*c' cannot wrap.
  assign twice     = {count_nxt, 1'b0};
  assign n_ext     = {1'b0, n};
  assign maj       = (twice > n_ext);
  assign tie       = (twice == n_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && bit_in)
      count <= count_nxt;
  end
endmodule

// File: rtl/temporal_bundler.sv
// temporal_bundler: bundles WINDOW encoded hypervectors (or fewer, when a
// flush ends the window early) into their bitwise majority.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : temporal_bundler_if.slave (in_valid/in_ready/hv_in, flush,
//              out_valid/out_ready/hv_out/out_count)
// Optional macro BUNDLE_TIEBREAK_EN: ties (2*c == n) resolve to the bit of
// the first vector of the window instead of 0.
module temporal_bundler
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = DIMENSIONS_DEFAULT,
  parameter int WINDOW     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  temporal_bundler_if.slave     bus
);
  localparam int CNT_W = cnt_width(WINDOW);

  bundler_state_t        state;
  logic [CNT_W-1:0]      vec_cnt;
  logic [CNT_W-1:0]      n;
  logic                  in_ready;
  logic                  accept;
  logic                  close;
  logic                  out_valid_r;
  logic [DIMENSIONS-1:0] hv_out_r;
  logic [CNT_W-1:0]      out_count_r;
  logic [DIMENSIONS-1:0] maj_w;
  logic [DIMENSIONS-1:0] tie_w;
  logic [DIMENSIONS-1:0] tie_src;
  logic [DIMENSIONS-1:0] maj_vec;

  assign in_ready = (state == ACCUM) && !rst;
  assign accept   = bus.in_valid && in_ready;
  // Effective window length counts an input accepted this same cycle.
  assign n        = vec_cnt + CNT_W'(accept);
  assign close    = (state == ACCUM) &&
                    ((accept && (n == CNT_W'(WINDOW))) || (bus.flush && (n != '0)));

`ifdef BUNDLE_TIEBREAK_EN
  logic [DIMENSIONS-1:0] tie_hv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tie_hv <= '0;
    else if (accept && (vec_cnt == '0))
      tie_hv <= bus.hv_in;
  end

  // A single-vector window closes on the very accept that would load tie_hv.
  assign tie_src = (vec_cnt == '0) ? bus.hv_in : tie_hv;
`else
  assign tie_src = '0;
`endif

  for (genvar i = 0; i < DIMENSIONS; i++) begin : g_dim
    bundle_bit_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (close),
      .inc    (accept),
      .bit_in (bus.hv_in[i]),
      .n      (n),
      .maj    (maj_w[i]),
      .tie    (tie_w[i])
    );
    assign maj_vec[i] = maj_w[i] | (tie_w[i] & tie_src[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      vec_cnt     <= '0;
      out_valid_r <= 1'b0;
      hv_out_r    <= '0;
      out_count_r <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (close) begin
            hv_out_r    <= maj_vec;
            out_count_r <= n;
            vec_cnt     <= '0;
            out_valid_r <= 1'b1;
            state       <= OUTPUT;
          end else if (accept) begin
            vec_cnt <= n;
          end
        end
        OUTPUT: begin
          // hv_out keeps its last value after the handoff.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.hv_out    = hv_out_r;
  assign bus.out_count = out_count_r;
endmodule
